uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart of the UART transmitter. Recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from an asynchronous `rx_line` and presents each byte with a one-cycle valid strobe. The block synchronises the line, rejects start-bit glitches, samples each bit at mid-bit and flags framing errors. In loopback it connects directly to the transmitter's `tx_line`. Baud configuration is shared with the transmitter.

## Interface
- `clk_freq`, 50000000, system clock frequency in Hz.
- `baud_rate`, 9600, line bit rate. Derived values:
  - N = `clk_freq/baud_rate` (integer division), clocks per bit; must satisfy 4 ≤ N ≤ 65535.
  - H = N/2 (integer division).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_line`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  last correctly received byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new in the same cycle.
- `rx_busy`  out  1  high while a frame is in progress (states START, DATA, STOP).
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- Synchroniser: two flops on `rx_line` produce `rx_sync`. Both flops reset to 1. No logic other than the synchroniser reads `rx_line` directly.
- Counter: `clk_count` is 16 bits; `bit_index` is 3 bits.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rx_sync` = 0, go to START with `clk_count` = 0.
  - START: at `clk_count` = H-1, sample the line.
    - Sample 1: glitch; return to IDLE with no output activity.
    - Sample 0: go to DATA with `clk_count` = 0 and `bit_index` = 0.
  - DATA: at `clk_count` = N-1, sample the line and shift it into bit `bit_index` of the shift register (LSB first), then reset `clk_count` to 0.
    - After bit 7, go to STOP.
  - STOP: at `clk_count` = N-1, sample the line.
    - Sample 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - Sample 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: remain until `rx_sync` = 1, then go to IDLE. This absorbs breaks, so a held-low line produces exactly one `frame_err`.
- `rx_valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames are supported. STOP returns to IDLE at mid-stop-bit, so a start edge arriving immediately after the stop bit is detected.

## Timing
- Reset values: `rx_data` = 0x00, `rx_valid` = 0, `rx_busy` = 0, `frame_err` = 0, state = IDLE, counters = 0, synchroniser = 1.
- Reset asserted mid-frame aborts the frame on that edge. No `rx_valid` or `frame_err` is produced for the aborted frame.
- Input latency: an `rx_line` transition is visible on `rx_sync` 2 clocks later.
- Let E be the edge on which IDLE first sees `rx_sync` = 0:
  - The start sample occurs at E+H.
  - Data bit k (k = 0..7) is sampled at E+H+(k+1)·N.
  - The stop bit is sampled at E+H+9·N.
  - `rx_valid` or `frame_err` is high during the cycle following the stop-sample edge, for exactly one cycle.
- `rx_busy` rises the cycle after E. It falls in the same cycle that `rx_valid` or `frame_err` is high, or the cycle after a rejected start.
- Tolerance: mid-bit sampling accepts a cumulative clock mismatch of up to about ±4% over the frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample (start, data and stop) is the 2-of-3 majority of `rx_sync` taken at the three consecutive cycles ending at the nominal sample cycle.
  - The vote decision is taken at the nominal sample cycle. All timing above is unchanged.
- Undefined: each sample is the single value of `rx_sync` at the nominal sample cycle.

## Test plan
All tests use `clk_freq` = 160 and `baud_rate` = 10, giving N = 16 and H = 8.
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) → `rx_data` = 0xA5 and a single-cycle `rx_valid` at E+8+144+1; `frame_err` stays 0.
- `rx_line` low for 3 cycles, then high → `rx_busy` pulses briefly and returns to 0; no `rx_valid`, no `frame_err`; `rx_data` unchanged.
- Frame 0x00 followed by the line held low for 40 bit times → exactly one `frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value. After the line returns high, frame 0x3C → `rx_valid` with `rx_data` = 0x3C.
- Frames 0x55 then 0xFF with zero idle gap → two `rx_valid` pulses, 160 cycles apart, carrying 0x55 then 0xFF.
- `reset` asserted for 1 cycle during data bit 3 of 0x81 → all outputs at reset values on the next edge, no strobe for the aborted frame. A following clean 0x3C frame is received correctly.
- With `UART_RX_MAJORITY_EN` defined: frame 0xFF with a 1-cycle low glitch placed exactly on the data bit 2 sample cycle → `rx_data` = 0xFF. Without the macro, the same stimulus gives `rx_data` = 0xFB.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, recovered byte and status strobes out.
interface uart_rx_if;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    modport master (output rx_line, input rx_data, rx_valid, rx_busy, frame_err);
    modport slave  (input rx_line, output rx_data, rx_valid, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchroniser, start-glitch rejection and mid-bit sampling.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three rx_sync values.
module uart_rx #(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 9600
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int          N        = clk_freq / baud_rate;
    localparam int          H        = N / 2;
    localparam logic [15:0] LAST_BIT = 16'(N - 1);
    localparam logic [15:0] MID_BIT  = 16'(H - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      state, state_n;
    logic [1:0]  sync_ff;
    logic        rx_sync;
    logic        sample;
    logic [15:0] clk_count, clk_count_n;
    logic [2:0]  bit_index, bit_index_n;
    logic [7:0]  shift_reg, shift_reg_n;
    logic [7:0]  data_q, data_n;
    logic        valid_q, valid_n;
    logic        ferr_q, ferr_n;

    assign rx_sync = sync_ff[1];

    always_ff @(posedge clk) begin
        if (reset) sync_ff <= 2'b11;
        else       sync_ff <= {sync_ff[0], bus.rx_line};
    end

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rx_sync one cycle back, hist[1] two cycles back
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (reset) hist <= 2'b11;
        else       hist <= {hist[0], rx_sync};
    end
    assign sample = (rx_sync & hist[0]) | (rx_sync & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = rx_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            clk_count <= clk_count_n;
            bit_index <= bit_index_n;
            shift_reg <= shift_reg_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            ferr_q    <= ferr_n;
        end
    end

    always_comb begin
        state_n     = state;
        clk_count_n = clk_count;
        bit_index_n = bit_index;
        shift_reg_n = shift_reg;
        data_n      = data_q;
        valid_n     = 1'b0;
        ferr_n      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_n     = START;
                    clk_count_n = '0;
                end
            end
            START: begin
                if (clk_count == MID_BIT) begin
                    if (sample) begin
                        state_n = IDLE;
                    end else begin
                        state_n     = DATA;
                        clk_count_n = '0;
                        bit_index_n = '0;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (clk_count == LAST_BIT) begin
                    shift_reg_n[bit_index] = sample;
                    clk_count_n            = '0;
                    if (bit_index == 3'd7) state_n = STOP;
                    else                   bit_index_n = bit_index + 3'd1;
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            STOP: begin
                // leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
                if (clk_count == LAST_BIT) begin
                    clk_count_n = '0;
                    if (sample) begin
                        data_n  = shift_reg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state == START) || (state == DATA) || (state == STOP);
endmodule
